// File: rtl/sram_wb_pkg.sv
// Shared types and sizing helpers for the banked Wishbone SRAM slave.
package sram_wb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } sram_wb_state_t;

  // Wide enough to hold the largest read latency (4).
  localparam int CNT_W = 3;

  // Bank-index width; a single bank still gets one bit so slices stay legal.
  function automatic int bank_idx_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/sram_for_FPGA.sv
// Behavioural SRAM macro: one masked write port, one read port whose
// output appears READ_LATENCY clock edges after the read strobe is sampled.
module sram_for_FPGA #(
  parameter int NUM_WMASKS   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 11,
  parameter int READ_LATENCY = 1
) (
`ifdef USE_POWER_PINS
  inout  wire                   vccd1,
  inout  wire                   vssd1,
`endif
  input  logic                  clk0,
  input  logic                  csb0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  input  logic                  clk1,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rd_pipe_q [READ_LATENCY];

  // Byte-masked write on port 0.
  always_ff @(posedge clk0) begin
    if (!csb0) begin
      for (int i = 0; i < NUM_WMASKS; i++) begin
        if (wmask0[i]) mem[addr0][i*8 +: 8] <= din0[i*8 +: 8];
      end
    end
  end

  // Read on port 1, then delay through the remaining latency stages.
  always_ff @(posedge clk1) begin
    if (!csb1) rd_pipe_q[0] <= mem[addr1];
    for (int i = 1; i < READ_LATENCY; i++) begin
      rd_pipe_q[i] <= rd_pipe_q[i-1];
    end
  end

  assign dout1 = rd_pipe_q[READ_LATENCY-1];

endmodule

// File: rtl/sram_wb_banked.sv
// Wishbone slave presenting NUM_BANKS SRAM macros as one word-addressed
// window at BASE_ADDR, with registered ack/err/data and cycle abort.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for stb&cyc; decodes and strobes the addressed bank
// RD_WAIT | read in flight; latency counter runs down, capture at 1
// RESP    | ack or err high for this one cycle; request ignored
module sram_wb_banked
  import sram_wb_pkg::*;
#(
  parameter int          NUM_BANKS    = 2,
  parameter int          ADDR_WIDTH   = 11,
  parameter int          DATA_WIDTH   = 32,
  parameter int          NUM_WMASKS   = 4,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000
) (
`ifdef USE_POWER_PINS
  inout  wire                   vccd1,
  inout  wire                   vssd1,
`endif
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [NUM_WMASKS-1:0] wbs_sel_i,
  input  logic [DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [31:0]           wbs_adr_i,
  output logic                  wbs_ack_o,
  output logic                  wbs_err_o,
  output logic [DATA_WIDTH-1:0] wbs_dat_o
);

  localparam int             BANK_W    = bank_idx_w(NUM_BANKS);
  localparam logic [31:0]    NUM_WORDS = 32'(NUM_BANKS) << ADDR_WIDTH;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY);

  sram_wb_state_t          state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BANK_W-1:0]       bank_q, bank_d;
  logic [NUM_WMASKS-1:0]   sel_q, sel_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   dat_q, dat_d;

  logic [31:0]             off;
  logic [31:0]             word;
  logic                    in_range;
  logic                    req;
  logic [BANK_W-1:0]       bank_sel;
  logic [ADDR_WIDTH-1:0]   row;
  logic                    wr_stb;
  logic                    rd_stb;
  logic [NUM_BANKS-1:0]    csb0_vec;
  logic [NUM_BANKS-1:0]    csb1_vec;
  logic [DATA_WIDTH-1:0]   dout_bank [NUM_BANKS];
  logic [DATA_WIDTH-1:0]   rd_raw;
  logic [DATA_WIDTH-1:0]   rd_masked;

  // Offsets below BASE_ADDR wrap to huge values and fall out of range.
  assign off      = wbs_adr_i - BASE_ADDR;
  assign word     = off >> 2;
  assign in_range = (word < NUM_WORDS);
  assign req      = wbs_stb_i & wbs_cyc_i;
  assign bank_sel = word[ADDR_WIDTH +: BANK_W];
  assign row      = word[ADDR_WIDTH-1:0];

  // Read mux from the bank latched at accept, masked by the latched sel.
  always_comb begin
    rd_raw    = dout_bank[bank_q];
    rd_masked = '0;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      rd_masked[i*8 +: 8] = sel_q[i] ? rd_raw[i*8 +: 8] : 8'h00;
    end
  end

  // Next-state, response and bank-strobe logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bank_d  = bank_q;
    sel_d   = sel_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dat_d   = '0;
    wr_stb  = 1'b0;
    rd_stb  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          state_d = RESP;
          if (!in_range) begin
            err_d = 1'b1;
          end else if (wbs_we_i) begin
            wr_stb = 1'b1;
            ack_d  = 1'b1;
          end else begin
            rd_stb  = 1'b1;
            bank_d  = bank_sel;
            sel_d   = wbs_sel_i;
            cnt_d   = LAT_LOAD;
            state_d = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (!wbs_cyc_i) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(1)) begin
          dat_d   = rd_masked;
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Only the addressed bank sees a chip select; the others stay high.
  always_comb begin
    csb0_vec = '1;
    csb1_vec = '1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_sel == BANK_W'(b)) begin
        csb0_vec[b] = ~wr_stb;
        csb1_vec[b] = ~rd_stb;
      end
    end
  end

  // State and response registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bank_q  <= '0;
      sel_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bank_q  <= bank_d;
      sel_q   <= sel_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_err_o = err_q;
  assign wbs_dat_o = dat_q;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    sram_for_FPGA #(
      .NUM_WMASKS   (NUM_WMASKS),
      .DATA_WIDTH   (DATA_WIDTH),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .READ_LATENCY (READ_LATENCY)
    ) u_sram (
`ifdef USE_POWER_PINS
      .vccd1  (vccd1),
      .vssd1  (vssd1),
`endif
      .clk0   (wb_clk_i),
      .csb0   (csb0_vec[g]),
      .wmask0 (wbs_sel_i),
      .addr0  (row),
      .din0   (wbs_dat_i),
      .clk1   (wb_clk_i),
      .csb1   (csb1_vec[g]),
      .addr1  (row),
      .dout1  (dout_bank[g])
    );
  end

endmodule

// File: tb/tb_sram_wb_banked.sv
// Directed bench for sram_wb_banked: one instance at default latency,
// one at READ_LATENCY = 3, sharing clock, reset and address/data buses.
module tb_sram_wb_banked;
  import sram_wb_pkg::*;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb_a, cyc_a, stb_b, cyc_b;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] dat_w;
  logic [31:0] adr;
  logic        ack_a, err_a, ack_b, err_b;
  logic [31:0] dat_a, dat_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_wb_banked dut (
    .wb_clk_i (clk),   .wb_rst_i (rst),
    .wbs_stb_i(stb_a), .wbs_cyc_i(cyc_a), .wbs_we_i(we),
    .wbs_sel_i(sel),   .wbs_dat_i(dat_w), .wbs_adr_i(adr),
    .wbs_ack_o(ack_a), .wbs_err_o(err_a), .wbs_dat_o(dat_a)
  );

  sram_wb_banked #(.READ_LATENCY(3)) dut3 (
    .wb_clk_i (clk),   .wb_rst_i (rst),
    .wbs_stb_i(stb_b), .wbs_cyc_i(cyc_b), .wbs_we_i(we),
    .wbs_sel_i(sel),   .wbs_dat_i(dat_w), .wbs_adr_i(adr),
    .wbs_ack_o(ack_b), .wbs_err_o(err_b), .wbs_dat_o(dat_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit u3, input logic v);
    if (u3) begin stb_b = v; cyc_b = v; end
    else    begin stb_a = v; cyc_a = v; end
  endtask

  function automatic logic get_ack(input bit u3);
    return u3 ? ack_b : ack_a;
  endfunction

  function automatic logic get_err(input bit u3);
    return u3 ? err_b : err_a;
  endfunction

  function automatic logic [31:0] get_dat(input bit u3);
    return u3 ? dat_b : dat_a;
  endfunction

  task automatic do_write(input bit u3, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input bit exp_err, input string nm);
    adr = a; dat_w = d; sel = s; we = 1'b1;
    drive_req(u3, 1'b1);
    #1;
    if (exp_err && !u3) begin
      total++;
      if (dut.csb0_vec !== 2'b11 || dut.csb1_vec !== 2'b11) begin
        bad++;
        $display("FAIL %s_csb: csb0=%b csb1=%b, want 11/11", nm, dut.csb0_vec, dut.csb1_vec);
      end
    end
    tick();
    total++;
    if (get_ack(u3) !== !exp_err || get_err(u3) !== exp_err) begin
      bad++;
      $display("FAIL %s_resp: ack=%b err=%b, want ack=%b err=%b", nm, get_ack(u3), get_err(u3), !exp_err, exp_err);
    end
    drive_req(u3, 1'b0); we = 1'b0;
    tick();
    total++;
    if (get_ack(u3) !== 1'b0 || get_err(u3) !== 1'b0) begin
      bad++;
      $display("FAIL %s_once: ack=%b err=%b, want 0/0", nm, get_ack(u3), get_err(u3));
    end
  endtask

  task automatic do_read(input bit u3, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] exp, input string nm);
    int lat;
    lat = u3 ? 3 : 1;
    adr = a; sel = s; we = 1'b0;
    drive_req(u3, 1'b1);
    for (int c = 1; c <= lat; c++) begin
      tick();
      total++;
      if (get_ack(u3) !== 1'b0 || get_err(u3) !== 1'b0) begin
        bad++;
        $display("FAIL %s_early c%0d: ack=%b err=%b, want 0/0", nm, c, get_ack(u3), get_err(u3));
      end
    end
    tick();
    total++;
    if (get_ack(u3) !== 1'b1 || get_err(u3) !== 1'b0 || get_dat(u3) !== exp) begin
      bad++;
      $display("FAIL %s_data: ack=%b err=%b dat=%h, want 1/0 %h", nm, get_ack(u3), get_err(u3), get_dat(u3), exp);
    end
    drive_req(u3, 1'b0);
    tick();
    total++;
    if (get_ack(u3) !== 1'b0 || get_dat(u3) !== 32'h0) begin
      bad++;
      $display("FAIL %s_after: ack=%b dat=%h, want 0 00000000", nm, get_ack(u3), get_dat(u3));
    end
  endtask

  task automatic test_reset();
    total++;
    if (ack_a !== 1'b0 || err_a !== 1'b0 || dat_a !== 32'h0 ||
        dut.csb0_vec !== 2'b11 || dut.csb1_vec !== 2'b11) begin
      bad++;
      $display("FAIL reset_idle: ack=%b err=%b dat=%h csb0=%b csb1=%b, want 0 0 0 11 11",
               ack_a, err_a, dat_a, dut.csb0_vec, dut.csb1_vec);
    end
    // Reset landing on an ack cycle must clear the outputs without a clock.
    do_write(1'b0, BASE, 32'h0000_00A5, 4'hF, 1'b0, "rst_wr");
    adr = BASE; sel = 4'hF; we = 1'b0;
    drive_req(1'b0, 1'b1);
    tick();
    tick();
    total++;
    if (ack_a !== 1'b1 || dat_a !== 32'h0000_00A5) begin
      bad++;
      $display("FAIL rst_pre_ack: ack=%b dat=%h, want 1 000000a5", ack_a, dat_a);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (ack_a !== 1'b0 || err_a !== 1'b0 || dat_a !== 32'h0) begin
      bad++;
      $display("FAIL rst_async: ack=%b err=%b dat=%h, want 0 0 0", ack_a, err_a, dat_a);
    end
    drive_req(1'b0, 1'b0);
    tick();
    rst = 1'b0;
    // Reset in the middle of a long read.
    adr = BASE + 32'h40; sel = 4'hF; we = 1'b0;
    drive_req(1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    total++;
    if (ack_b !== 1'b0 || err_b !== 1'b0 || dat_b !== 32'h0 || dut3.state_q !== IDLE) begin
      bad++;
      $display("FAIL rst_midread: ack=%b err=%b dat=%h state=%0d, want 0 0 0 IDLE",
               ack_b, err_b, dat_b, dut3.state_q);
    end
    drive_req(1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      total++;
      if (ack_b !== 1'b0 || err_b !== 1'b0) begin
        bad++;
        $display("FAIL rst_noack c%0d: ack=%b err=%b, want 0/0", c, ack_b, err_b);
      end
    end
  endtask

  task automatic test_full_word();
    adr = BASE + 32'h10; dat_w = 32'hDEAD_BEEF; sel = 4'hF; we = 1'b1;
    drive_req(1'b0, 1'b1);
    #1;
    total++;
    if (dut.csb0_vec !== 2'b10 || dut.csb1_vec !== 2'b11) begin
      bad++;
      $display("FAIL fw_strobe: csb0=%b csb1=%b, want 10/11", dut.csb0_vec, dut.csb1_vec);
    end
    tick();
    total++;
    if (ack_a !== 1'b1 || err_a !== 1'b0) begin
      bad++;
      $display("FAIL fw_wack: ack=%b err=%b, want 1/0", ack_a, err_a);
    end
    drive_req(1'b0, 1'b0); we = 1'b0;
    tick();
    do_read(1'b0, BASE + 32'h10, 4'hF, 32'hDEAD_BEEF, "fw_rd");
  endtask

  task automatic test_byte_lanes();
    do_write(1'b0, BASE + 32'h20, 32'h1122_3344, 4'hF, 1'b0, "bl_w0");
    do_write(1'b0, BASE + 32'h20, 32'hAA00_00BB, 4'b1001, 1'b0, "bl_w1");
    do_read(1'b0, BASE + 32'h20, 4'b1111, 32'hAA22_33BB, "bl_rF");
    do_read(1'b0, BASE + 32'h20, 4'b0011, 32'h0000_33BB, "bl_r3");
    do_write(1'b0, BASE + 32'h24, 32'h5566_7788, 4'h0, 1'b0, "bl_sel0");
  endtask

  task automatic test_bank_boundary();
    do_write(1'b0, BASE + 32'h1FFC, 32'h0A0A_0A0A, 4'hF, 1'b0, "bb_w2047");
    do_write(1'b0, BASE + 32'h2000, 32'h0B0B_0B0B, 4'hF, 1'b0, "bb_w2048");
    do_write(1'b0, BASE + 32'h3FFC, 32'h0C0C_0C0C, 4'hF, 1'b0, "bb_wlast");
    total++;
    if (dut.g_bank[0].u_sram.mem[2047] !== 32'h0A0A_0A0A ||
        dut.g_bank[1].u_sram.mem[0]    !== 32'h0B0B_0B0B) begin
      bad++;
      $display("FAIL bb_cells: b0r2047=%h b1r0=%h, want 0a0a0a0a 0b0b0b0b",
               dut.g_bank[0].u_sram.mem[2047], dut.g_bank[1].u_sram.mem[0]);
    end
    do_read(1'b0, BASE + 32'h1FFC, 4'hF, 32'h0A0A_0A0A, "bb_r2047");
    do_read(1'b0, BASE + 32'h2000, 4'hF, 32'h0B0B_0B0B, "bb_r2048");
    do_read(1'b0, BASE + 32'h3FFC, 4'hF, 32'h0C0C_0C0C, "bb_rlast");
    do_write(1'b0, BASE + 32'h4000, 32'hFFFF_FFFF, 4'hF, 1'b1, "bb_oor");
    do_write(1'b0, BASE - 32'h4, 32'hFFFF_FFFF, 4'hF, 1'b1, "bb_wrap");
    // An out-of-range read also errors in cycle 1.
    adr = BASE + 32'h4000; sel = 4'hF; we = 1'b0;
    drive_req(1'b0, 1'b1);
    tick();
    total++;
    if (ack_a !== 1'b0 || err_a !== 1'b1) begin
      bad++;
      $display("FAIL bb_rd_oor: ack=%b err=%b, want 0/1", ack_a, err_a);
    end
    drive_req(1'b0, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    adr = BASE + 32'h30; dat_w = 32'h1111_1111; sel = 4'hF; we = 1'b1;
    drive_req(1'b0, 1'b1);
    tick();
    total++;
    if (ack_a !== 1'b1) begin
      bad++;
      $display("FAIL b2b_c1: ack=%b, want 1", ack_a);
    end
    dat_w = 32'h5555_5555;
    tick();
    total++;
    if (ack_a !== 1'b0) begin
      bad++;
      $display("FAIL b2b_c2: ack=%b, want 0", ack_a);
    end
    tick();
    total++;
    if (ack_a !== 1'b1) begin
      bad++;
      $display("FAIL b2b_c3: ack=%b, want 1", ack_a);
    end
    drive_req(1'b0, 1'b0); we = 1'b0;
    tick();
    total++;
    if (ack_a !== 1'b0) begin
      bad++;
      $display("FAIL b2b_c4: ack=%b, want 0", ack_a);
    end
    do_read(1'b0, BASE + 32'h30, 4'hF, 32'h5555_5555, "b2b_rd");
  endtask

  task automatic test_latency_abort();
    do_write(1'b1, BASE + 32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, "lat_w");
    do_read(1'b1, BASE + 32'h40, 4'hF, 32'hCAFE_F00D, "lat_rd");
    adr = BASE + 32'h40; sel = 4'hF; we = 1'b0;
    drive_req(1'b1, 1'b1);
    tick();
    tick();
    cyc_b = 1'b0;
    for (int c = 2; c < 7; c++) begin
      tick();
      total++;
      if (ack_b !== 1'b0 || err_b !== 1'b0 || dat_b !== 32'h0) begin
        bad++;
        $display("FAIL abort c%0d: ack=%b err=%b dat=%h, want 0 0 0", c, ack_b, err_b, dat_b);
      end
    end
    stb_b = 1'b0;
    do_write(1'b1, BASE + 32'h44, 32'h0123_4567, 4'hF, 1'b0, "abort_w");
    do_read(1'b1, BASE + 32'h44, 4'hF, 32'h0123_4567, "abort_rd");
  endtask

  initial begin
    rst = 1'b1;
    stb_a = 1'b0; cyc_a = 1'b0; stb_b = 1'b0; cyc_b = 1'b0;
    we = 1'b0; sel = 4'h0; dat_w = 32'h0; adr = BASE;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_bank_boundary();
    test_back_to_back();
    test_latency_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
